// File: rtl/keylock_pkg.sv
// Shared key codes and FSM state encoding for the keypad lock controller.
package keylock_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  typedef logic [2:0] state_t;

  localparam state_t ST_LOCKED       = 3'd0;
  localparam state_t ST_OPEN         = 3'd1;
  localparam state_t ST_PROG_AUTH    = 3'd2;
  localparam state_t ST_PROG_NEW     = 3'd3;
  localparam state_t ST_PROG_CONFIRM = 3'd4;
  localparam state_t ST_LOCKOUT      = 3'd5;

  function automatic logic key_is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  // Keys 4'hD..4'hF carry no meaning and are dropped everywhere.
  function automatic logic key_is_known(input logic [3:0] k);
    return k <= KEY_CHANGE;
  endfunction

endpackage

// File: rtl/code_entry_buf.sv
// Digit entry buffer: BCD shift register with saturating count and two equality taps.
module code_entry_buf #(
  parameter int N_DIGITS = 6,
  localparam int W = 4*N_DIGITS
) (
  input  logic         hwclk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [3:0]   digit,
  input  logic [W-1:0] cmp_a,
  input  logic [W-1:0] cmp_b,
  output logic [W-1:0] value,
  output logic [3:0]   count,
  output logic         len_ok,
  output logic         match_a,
  output logic         match_b
);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (push) begin
      // Once full, the next digit only marks overflow; the value is frozen.
      if (count < 4'(N_DIGITS)) begin
        value <= W'({value, digit});
        count <= count + 4'd1;
      end else begin
        count <= 4'(N_DIGITS + 1);
      end
    end
  end

  assign len_ok  = (count == 4'(N_DIGITS));
  assign match_a = len_ok && (value == cmp_a);
  assign match_b = len_ok && (value == cmp_b);

endmodule

// File: rtl/keylock_core.sv
// Keypad lock controller: code entry, master/user check, code change, relock, timeout, lockout.
module keylock_core
  import keylock_pkg::*;
#(
  parameter int                    N_DIGITS       = 6,
  parameter logic [4*N_DIGITS-1:0] MASTER_CODE    = 24'h555116,
  parameter logic [4*N_DIGITS-1:0] DEFAULT_UC     = 24'h666666,
  parameter int                    MAX_FAILS      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 60000000,
  parameter int unsigned           OPEN_CYCLES    = 120000000,
  parameter int unsigned           ENTRY_TIMEOUT  = 60000000
) (
  input  logic                           hwclk,
  input  logic                           resetN,
  input  logic                           key_valid,
  input  logic [3:0]                     key,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           prog_mode,
  output logic                           ok_pulse,
  output logic                           err_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic [3:0]                     digits_entered
);

  localparam int W    = 4*N_DIGITS;
  localparam int FC_W = $clog2(MAX_FAILS+1);
  localparam int LT_W = $clog2(LOCKOUT_CYCLES+1);
  localparam int OT_W = (OPEN_CYCLES > 0) ? $clog2(OPEN_CYCLES+1) : 1;
  localparam int ET_W = $clog2(ENTRY_TIMEOUT+1);

  logic [1:0]     rst_sync;
  logic           rst_n;
  state_t         state;
  logic [W-1:0]   user_code, cand;
  logic [LT_W-1:0] ltmr;
  logic [OT_W-1:0] otmr;
  logic [ET_W-1:0] etmr;

  logic           is_digit, is_clear, is_enter, is_change, accept, prog;
  logic           idle_run, idle_exp, open_exp, lock_exp, fail_last;
  logic           buf_clr, buf_push, len_ok, match_a, match_b;
  logic [W-1:0]   buf_val, cmp_a;
  logic [3:0]     buf_cnt;

  // Reset asserts asynchronously, releases on the clock.
  always_ff @(posedge hwclk or negedge resetN) begin
    if (!resetN) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign is_digit  = key_is_digit(key);
  assign is_clear  = (key == KEY_CLEAR);
  assign is_enter  = (key == KEY_ENTER);
  assign is_change = (key == KEY_CHANGE);
  assign prog      = (state == ST_PROG_AUTH) || (state == ST_PROG_NEW) ||
                     (state == ST_PROG_CONFIRM);

  // OPEN only listens for ENTER; LOCKOUT listens to nothing.
  assign accept = key_valid && key_is_known(key) && (state != ST_LOCKOUT) &&
                  ((state != ST_OPEN) || is_enter);

  assign idle_run  = ((state == ST_LOCKED) && (buf_cnt != 4'd0)) || prog;
  assign idle_exp  = idle_run && !accept && (etmr == ET_W'(1));
  assign open_exp  = (state == ST_OPEN) && (OPEN_CYCLES != 0) && (otmr == OT_W'(1));
  assign lock_exp  = (state == ST_LOCKOUT) && (ltmr == LT_W'(1));
  assign fail_last = (fail_cnt == FC_W'(MAX_FAILS - 1));

  assign buf_push = accept && is_digit;
  assign buf_clr  = (accept && (is_clear || is_enter || is_change)) || idle_exp;
  assign cmp_a    = (state == ST_PROG_CONFIRM) ? cand : user_code;

  code_entry_buf #(.N_DIGITS(N_DIGITS)) u_buf (
    .hwclk   (hwclk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .push    (buf_push),
    .digit   (key),
    .cmp_a   (cmp_a),
    .cmp_b   (MASTER_CODE),
    .value   (buf_val),
    .count   (buf_cnt),
    .len_ok  (len_ok),
    .match_a (match_a),
    .match_b (match_b)
  );

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOCKED;
      user_code <= DEFAULT_UC;
      cand      <= '0;
      fail_cnt  <= '0;
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      ltmr      <= '0;
      otmr      <= '0;
      etmr      <= '0;
    end else begin
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;

      if (accept)                          etmr <= ET_W'(ENTRY_TIMEOUT);
      else if (idle_run && etmr != '0)     etmr <= etmr - ET_W'(1);
      if (state == ST_OPEN && otmr != '0)    otmr <= otmr - OT_W'(1);
      if (state == ST_LOCKOUT && ltmr != '0) ltmr <= ltmr - LT_W'(1);

      if (accept && is_enter) begin
        case (state)
          ST_LOCKED, ST_PROG_AUTH: begin
            if ((state == ST_LOCKED) && (match_a || match_b)) begin
              state    <= ST_OPEN;
              ok_pulse <= 1'b1;
              fail_cnt <= '0;
              otmr     <= OT_W'(OPEN_CYCLES);
            end else if ((state == ST_PROG_AUTH) && match_b) begin
              state <= ST_PROG_NEW;
            end else begin
              err_pulse <= 1'b1;
              fail_cnt  <= fail_cnt + FC_W'(1);
              ltmr      <= LT_W'(LOCKOUT_CYCLES);
              state     <= fail_last ? ST_LOCKOUT : ST_LOCKED;
            end
          end
          ST_OPEN: begin
            state    <= ST_LOCKED;
            ok_pulse <= 1'b1;
          end
          ST_PROG_NEW: begin
            if (len_ok) begin
              cand  <= buf_val;
              state <= ST_PROG_CONFIRM;
            end else begin
              err_pulse <= 1'b1;
              state     <= ST_LOCKED;
            end
          end
          ST_PROG_CONFIRM: begin
            if (match_a) begin
              user_code <= cand;
              ok_pulse  <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
            end
            state <= ST_LOCKED;
          end
          default: state <= ST_LOCKED;
        endcase
      end else if (accept && is_change) begin
        // CHANGE enters programming from LOCKED and aborts it from any PROG state.
        state <= (state == ST_LOCKED) ? ST_PROG_AUTH : ST_LOCKED;
      end else if (!accept) begin
        if (open_exp || idle_exp) state <= ST_LOCKED;
        if (lock_exp) begin
          state    <= ST_LOCKED;
          fail_cnt <= '0;
        end
      end
    end
  end

  assign unlocked       = (state == ST_OPEN);
  assign locked_out     = (state == ST_LOCKOUT);
  assign prog_mode      = prog;
  assign digits_entered = buf_cnt;

endmodule
